msi_snoop_bus: RTL

Parametrised shared-bus controller for the MSI cache system: serialises coherence requests from NUM_CORES cache controllers and broadcasts each as a snoop. Sources line data from a Modified holder (with write-back) or from memory. Successor to the single-core core/cache top: the bus grows from one cache to N caches with real coherence traffic, round-robin fairness and a memory handshake on ready_mem. Sits between the per-core caches and the memory model.

---
 rtl/msi_snoop_bus_pkg.sv | 20 ++
 rtl/msi_snoop_bus_rr_arbiter.sv | 32 +++
 rtl/msi_snoop_bus.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/msi_snoop_bus_pkg.sv
// Shared MSI bus definitions: bus command codes and bus controller state
// encoding. Imported by the snoop bus and by the per-core cache controllers.
package msi_pkg;

    // Bus command codes carried on req_cmd / snoop_cmd
    localparam logic [1:0] BUS_NONE = 2'b00;
    localparam logic [1:0] BUS_RD   = 2'b01;
    localparam logic [1:0] BUS_RDX  = 2'b10;
    localparam logic [1:0] BUS_UPGR = 2'b11;

    // Bus controller states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SNOOP  = 3'd1,
        ST_MEM_RD = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

endpackage

// File: rtl/msi_snoop_bus_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping.
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - highest-priority index for this decision
//   grant - one-hot grant (all zero when nothing requests), combinational
module rr_arbiter #(
    parameter  int unsigned N     = 2,
    localparam int unsigned PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    logic             found;
    logic [PTR_W-1:0] idx;

    // Scan N positions starting at ptr; the first requester found wins
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = PTR_W'((32'(ptr) + i) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/msi_snoop_bus.sv
// MSI shared-bus controller: arbitrates coherence requests round-robin,
// broadcasts each as a snoop, and sources line data from a Modified holder
// (with write-back) or from memory.
// Ports:
//   clk, reset_n                 - clock, async active-low reset
//   req_valid/req_cmd/req_addr   - per-core requests (held until done)
//   grant, done, rsp_data        - per-core ownership, completion, data
//   snoop_valid/cmd/addr/src     - snoop broadcast (decoded from state)
//   snoop_hit_m, snoop_data      - per-core Modified response, same cycle
//   mem_rd/mem_wr/mem_addr/mem_wdata, mem_rdata, ready_mem - memory port
//   coh_err                      - pulse when several cores claim Modified
module msi_snoop_bus
    import msi_pkg::*;
#(
    parameter  int unsigned NUM_CORES = 2,
    parameter  int unsigned ADDR_W    = 16,
    parameter  int unsigned LINE_W    = 16,
    localparam int unsigned PTR_W     = $clog2(NUM_CORES)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_CORES-1:0]          req_valid,
    input  logic [2*NUM_CORES-1:0]        req_cmd,
    input  logic [ADDR_W*NUM_CORES-1:0]   req_addr,
    output logic [NUM_CORES-1:0]          grant,
    output logic [NUM_CORES-1:0]          done,
    output logic [LINE_W-1:0]             rsp_data,
    output logic                          snoop_valid,
    output logic [1:0]                    snoop_cmd,
    output logic [ADDR_W-1:0]             snoop_addr,
    output logic [NUM_CORES-1:0]          snoop_src,
    input  logic [NUM_CORES-1:0]          snoop_hit_m,
    input  logic [LINE_W*NUM_CORES-1:0]   snoop_data,
    output logic                          mem_rd,
    output logic                          mem_wr,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [LINE_W-1:0]             mem_wdata,
    input  logic [LINE_W-1:0]             mem_rdata,
    input  logic                          ready_mem,
    output logic                          coh_err
);

    state_t                 state;
    logic [PTR_W-1:0]       rr_ptr;
    logic [1:0]             cmd_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [NUM_CORES-1:0]   winner_q;
    logic [LINE_W-1:0]      line_q;

    logic [NUM_CORES-1:0]   eligible;
    logic [NUM_CORES-1:0]   arb_grant;
    logic [PTR_W-1:0]       win_idx;
    logic [PTR_W-1:0]       next_ptr;
    logic [1:0]             sel_cmd;
    logic [ADDR_W-1:0]      sel_addr;
    logic [NUM_CORES-1:0]   hit;
    logic                   hit_found;
    logic [LINE_W-1:0]      hit_data;
    logic                   multi_hit;

    // A core competes only with a real command
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            eligible[i] = req_valid[i] & (req_cmd[2*i +: 2] != BUS_NONE);
        end
    end

    rr_arbiter #(.N(NUM_CORES)) u_arb (
        .req   (eligible),
        .ptr   (rr_ptr),
        .grant (arb_grant)
    );

    // Winner index plus its command/address, selected by the one-hot grant
    always_comb begin
        win_idx  = '0;
        sel_cmd  = '0;
        sel_addr = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (arb_grant[i]) begin
                win_idx  = PTR_W'(i);
                sel_cmd  = req_cmd[2*i +: 2];
                sel_addr = req_addr[ADDR_W*i +: ADDR_W];
            end
        end
    end

    assign next_ptr = (win_idx == PTR_W'(NUM_CORES - 1)) ? '0 : win_idx + PTR_W'(1);

    // The requester's own hit is never a hit; lowest-index holder supplies data
    assign hit = snoop_hit_m & ~winner_q;

    always_comb begin
        hit_found = 1'b0;
        hit_data  = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (hit[i] && !hit_found) begin
                hit_found = 1'b1;
                hit_data  = snoop_data[LINE_W*i +: LINE_W];
            end
        end
    end

    assign multi_hit = ($countones(hit) > 1);

    // Snoop and memory strobes decode directly from state and latched values
    assign snoop_valid = (state == ST_SNOOP);
    assign snoop_cmd   = snoop_valid ? cmd_q    : '0;
    assign snoop_addr  = snoop_valid ? addr_q   : '0;
    assign snoop_src   = snoop_valid ? winner_q : '0;
    assign mem_rd      = (state == ST_MEM_RD);
    assign mem_wr      = (state == ST_FLUSH);
    assign mem_addr    = (mem_rd || mem_wr) ? addr_q : '0;
    assign mem_wdata   = mem_wr ? line_q : '0;

    // Bus FSM with registered grant/done/rsp_data/coh_err
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            cmd_q    <= '0;
            addr_q   <= '0;
            winner_q <= '0;
            line_q   <= '0;
            grant    <= '0;
            done     <= '0;
            rsp_data <= '0;
            coh_err  <= 1'b0;
        end else begin
            done    <= '0;
            coh_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|eligible) begin
                        cmd_q    <= sel_cmd;
                        addr_q   <= sel_addr;
                        winner_q <= arb_grant;
                        grant    <= arb_grant;
                        rr_ptr   <= next_ptr;
                        state    <= ST_SNOOP;
                    end
                end
                ST_SNOOP: begin
                    if (cmd_q == BUS_UPGR) begin
                        // Upgrade needs no data; other sharers invalidate on the snoop
                        line_q   <= '0;
                        rsp_data <= '0;
                        done     <= winner_q;
                        state    <= ST_RESP;
                    end else if (hit_found) begin
                        line_q  <= hit_data;
                        coh_err <= multi_hit;
                        state   <= ST_FLUSH;
                    end else begin
                        state <= ST_MEM_RD;
                    end
                end
                ST_MEM_RD: begin
                    if (ready_mem) begin
                        line_q   <= mem_rdata;
                        rsp_data <= mem_rdata;
                        done     <= winner_q;
                        state    <= ST_RESP;
                    end
                end
                ST_FLUSH: begin
                    // Flushed line is written back and forwarded to the requester
                    if (ready_mem) begin
                        rsp_data <= line_q;
                        done     <= winner_q;
                        state    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    grant    <= '0;
                    rsp_data <= '0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
